spike_aer_encoder: RTL and testbench
====================================

SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

Interface
REQ-001 SHALL have parameter N_NEURONS, default 8, number of spike inputs (power of two, 2..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, event buffer entries (power of two, 2..16).
REQ-003 SHALL have parameter TS_WIDTH, default 8, timestamp width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port spike_in  input  N_NEURONS  per-neuron spike flags from the neuron array, level-sampled each cycle.
REQ-007 SHALL have port out_valid  output  1  head event available.
REQ-008 SHALL have port out_ready  input  1  consumer accepts head event.
REQ-009 SHALL have port out_addr  output  log2(N_NEURONS)  neuron index of head event.
REQ-010 SHALL have port out_ts  output  TS_WIDTH  timestamp of head event.
REQ-011 SHALL have port fifo_count  output  log2(FIFO_DEPTH)+1  number of buffered events.
REQ-012 SHALL have port drop_count  output  8  saturating count of merged (lost) spikes.

Function
REQ-013 SHALL keep a pending register; each edge: pending <= (pending & ~grant) | spike_in.
REQ-014 SHALL increment drop_count when spike_in[i]=1 while pending[i]=1 and bit i is not granted that cycle; one increment per cycle max, saturating at 255.
REQ-015 SHALL grant at most one pending bit per cycle, only when fifo_count < FIFO_DEPTH at the start of that cycle; a pop in the same cycle does not enable a grant.
REQ-016 SHALL, on a grant, write {index, ts_counter} into the FIFO tail at that edge and clear the granted pending bit.
REQ-017 SHALL run ts_counter as a free-running TS_WIDTH counter, +1 every cycle, wrapping from all-ones to 0.
REQ-018 SHALL pop the head when out_valid & out_ready at an edge; out_valid = (fifo_count != 0), out_addr/out_ts driven from FIFO head registers.
REQ-019 SHALL hold out_addr/out_ts stable while out_valid=1 and out_ready=0.
REQ-020 SHALL support simultaneous push and pop: fifo_count unchanged, order preserved (FIFO).
REQ-021 SHALL have latency: spike_in high before edge k -> pending at k -> earliest push at k+1 -> out_valid high after k+1.
REQ-022 SHALL, when FIFO full, hold pending bits (no loss except merges per REQ-014).
REQ-023 SHALL ignore out_ready when fifo_count = 0 (no underflow, pointers unchanged).

Reset
REQ-024 SHALL, on reset_n low, immediately clear pending, FIFO pointers, fifo_count, ts_counter, drop_count, round-robin pointer; out_valid=0, out_addr=0, out_ts=0.
REQ-025 SHALL discard all buffered and pending events on reset mid-operation; resume counting from ts 0 on first edge after release.

Configuration
REQ-026 SHALL use macro AER_ROUND_ROBIN_EN: defined -> grant is first pending index strictly after last granted index (wrapping), pointer reset to N_NEURONS-1 so index 0 wins first; undefined -> fixed priority, lowest pending index wins.

Verification
REQ-027 Single spike: spike_in=8'h04 for one cycle after reset at ts 0 -> one event addr=2, ts=1, out_valid after 2 edges.
REQ-028 Burst: spike_in=8'hFF one cycle, out_ready=1 -> 8 events, addrs 0..7 in order, consecutive ts, drop_count=0.
REQ-029 Backpressure: out_ready=0, spike_in=8'hFF one cycle -> fifo_count saturates at 4, pending holds 4 bits; release out_ready -> remaining 4 delivered, no loss.
REQ-030 Merge: spike_in[3] held 3 cycles with out_ready=0 and FIFO full -> drop_count=2, one event addr=3.
REQ-031 Arbitration: spike_in bits 0 and 1 held continuously, out_ready=1 -> with AER_ROUND_ROBIN_EN addrs alternate 0,1,0,1; without, addr 0 every grant, drop_count climbs.
REQ-032 Async reset: assert reset_n low mid-burst between edges -> out_valid, fifo_count, drop_count go 0 without a clock edge.

Source files
------------

// File: rtl/spike_aer_encoder.sv
// Address-event encoder: latches per-neuron spikes, arbitrates one per cycle into a
// timestamped FIFO. Define AER_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority).
module spike_aer_encoder #(
    parameter int N_NEURONS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TS_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_NEURONS-1:0]          spike_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(N_NEURONS)-1:0]  out_addr,
    output logic [TS_WIDTH-1:0]           out_ts,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    drop_count
);
    localparam int AW = $clog2(N_NEURONS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [N_NEURONS-1:0] pending_q, pending_d;
    logic [TS_WIDTH-1:0]  ts_q, ts_d;
    logic [7:0]           drop_q, drop_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;

    logic [AW-1:0]        mem_addr [FIFO_DEPTH];
    logic [TS_WIDTH-1:0]  mem_ts   [FIFO_DEPTH];

    logic                 grant_vld;
    logic [AW-1:0]        grant_idx;
    logic [N_NEURONS-1:0] grant_vec;
    logic                 push, pop;

`ifdef AER_ROUND_ROBIN_EN
    logic [AW-1:0] rr_ptr_q, rr_ptr_d;
    logic [AW-1:0] cand;

    // Scan downward in distance so the nearest pending index after rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = N_NEURONS; k >= 1; k--) begin
            cand = rr_ptr_q + AW'(k);
            if (pending_q[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        if (count_q >= DEPTH_C) begin
            grant_vld = 1'b0;
        end
        rr_ptr_d = grant_vld ? grant_idx : rr_ptr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= AW'(N_NEURONS - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant_vld = 1'b1;
                grant_idx = AW'(i);
            end
        end
        if (count_q >= DEPTH_C) begin
            grant_vld = 1'b0;
        end
    end
`endif

    always_comb begin
        grant_vec = grant_vld ? (N_NEURONS'(1) << grant_idx) : '0;
        push      = grant_vld;
        pop       = (count_q != '0) && out_ready;

        pending_d = (pending_q & ~grant_vec) | spike_in;
        ts_d      = ts_q + TS_WIDTH'(1);

        // A spike landing on a still-pending, ungranted bit is merged and counted once per cycle.
        drop_d = drop_q;
        if ((|(spike_in & pending_q & ~grant_vec)) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            ts_q      <= '0;
            drop_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            ts_q      <= ts_d;
            drop_q    <= drop_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr_q] <= grant_idx;
            mem_ts[wr_ptr_q]   <= ts_q;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_addr   = out_valid ? mem_addr[rd_ptr_q] : '0;
    assign out_ts     = out_valid ? mem_ts[rd_ptr_q] : '0;
    assign fifo_count = count_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder: expected {addr, ts} events are queued by the
// stimulus and popped by an independent monitor whenever the DUT hands off an event.
module tb_spike_aer_encoder;
  localparam int N   = 8;
  localparam int D   = 4;
  localparam int TSW = 8;
  localparam int AW  = 3;
  localparam int EW  = AW + TSW;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   spike_in = '0;
  logic           out_ready = 1'b0;
  logic           out_valid;
  logic [AW-1:0]  out_addr;
  logic [TSW-1:0] out_ts;
  logic [2:0]     fifo_count;
  logic [7:0]     drop_count;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  spike_aer_encoder #(.N_NEURONS(N), .FIFO_DEPTH(D), .TS_WIDTH(TSW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .spike_in   (spike_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_ts     (out_ts),
    .fifo_count (fifo_count),
    .drop_count (drop_count)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int addr, input int ts);
    exp_q.push_back({AW'(addr), TSW'(ts)});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: got addr=%0d ts=%0d, none expected", out_addr, out_ts);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({out_addr, out_ts} !== e) begin
          failures++;
          $display("FAIL event: got addr=%0d ts=%0d expected addr=%0d ts=%0d",
                   out_addr, out_ts, e[EW-1:TSW], e[TSW-1:0]);
        end
      end
    end
  end

  // Leaves the bench 1 time unit after edge 0 with reset released, ts_counter at 0.
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n   = 1'b0;
    spike_in  = '0;
    out_ready = 1'b0;
    exp_q.delete();
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_drop",  32'(drop_count), 0);
    chk("rst_addr_ts", 32'({out_addr, out_ts}), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: %0d events still outstanding, expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    // single spike: latency and timestamp
    do_reset();
    expect_ev(2, 1);
    spike_in = 8'h04;
    edges(1);
    spike_in = '0;
    chk("single_valid_e1", 32'(out_valid), 0);
    edges(1);
    chk("single_valid_e2", 32'(out_valid), 1);
    chk("single_count_e2", 32'(fifo_count), 1);
    out_ready = 1'b1;
    wait_drain("single", 20);
    chk("single_count_end", 32'(fifo_count), 0);

    // burst with consumer always ready; also exercises ready while empty
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) expect_ev(i, i + 1);
    spike_in = 8'hFF;
    edges(1);
    spike_in = '0;
    wait_drain("burst", 40);
    chk("burst_drop", 32'(drop_count), 0);
    chk("burst_count", 32'(fifo_count), 0);

    // backpressure: fill, hold head, then release
    do_reset();
    for (int i = 0; i < 4; i++) expect_ev(i, i + 1);
    for (int i = 4; i < 8; i++) expect_ev(i, i + 7);
    spike_in = 8'hFF;
    edges(1);
    spike_in = '0;
    edges(9);
    chk("bp_count_full", 32'(fifo_count), 4);
    chk("bp_head_held", 32'({out_addr, out_ts}), 32'({3'd0, 8'd1}));
    out_ready = 1'b1;
    wait_drain("bp", 40);
    chk("bp_drop", 32'(drop_count), 0);

    // merge while full
    do_reset();
    for (int i = 0; i < 4; i++) expect_ev(i, i + 1);
    expect_ev(3, 11);
    spike_in = 8'h0F;
    edges(1);
    spike_in = '0;
    edges(5);
    spike_in = 8'h08;
    edges(3);
    spike_in = '0;
    edges(1);
    chk("merge_drop", 32'(drop_count), 2);
    chk("merge_count", 32'(fifo_count), 4);
    out_ready = 1'b1;
    wait_drain("merge", 40);
    chk("merge_drop_end", 32'(drop_count), 2);

    // arbitration between two continuously spiking neurons
    do_reset();
`ifdef AER_ROUND_ROBIN_EN
    expect_ev(0, 1); expect_ev(1, 2); expect_ev(0, 3); expect_ev(1, 4);
    expect_ev(0, 5); expect_ev(1, 6); expect_ev(0, 7);
`else
    for (int i = 1; i <= 6; i++) expect_ev(0, i);
    expect_ev(1, 7);
`endif
    out_ready = 1'b1;
    spike_in  = 8'h03;
    edges(6);
    spike_in  = '0;
    wait_drain("arb", 40);
    chk("arb_drop", 32'(drop_count), 5);

    // asynchronous reset mid-burst, then resume from ts 0
    do_reset();
    spike_in = 8'hFF;
    edges(3);
    spike_in = '0;
    edges(1);
    #2;
    chk("areset_pre_count", 32'(fifo_count), 3);
    chk("areset_pre_drop", 32'(drop_count), 2);
    reset_n = 1'b0;
    #1;
    chk("areset_valid", 32'(out_valid), 0);
    chk("areset_count", 32'(fifo_count), 0);
    chk("areset_drop", 32'(drop_count), 0);
    chk("areset_addr_ts", 32'({out_addr, out_ts}), 0);
    do_reset();
    expect_ev(2, 1);
    spike_in = 8'h04;
    edges(1);
    spike_in  = '0;
    out_ready = 1'b1;
    wait_drain("resume", 20);
    edges(3);
    chk("resume_count", 32'(fifo_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
